// File: rtl/nes_oam_dma.sv
// NES sprite DMA: a write to TRIGGER_ADDR halts the CPU and copies page {page,00..FF}
// to the PPU OAM data port as 256 read/write pairs, with every read on an even cycle.
module nes_oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    input  logic [7:0]  mem_di,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_do,
    output logic        dma_rw,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_q;

    logic        rdy_q, rdy_d;
    logic        dma_active_q, dma_active_d;
    logic        busy_q, busy_d;
    logic [15:0] dma_a_q, dma_a_d;
    logic [7:0]  dma_do_q, dma_do_d;
    logic        dma_rw_q, dma_rw_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= ~par_q;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (!cpu_rw && cpu_a == TRIGGER_ADDR) begin
                    page_d  = cpu_do;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            // The 6502 only stops on a read cycle, so wait out any pending writes.
            HALT: begin
                if (cpu_rw) state_d = ALIGN;
            end
            ALIGN: begin
                if (par_q) state_d = READ;
            end
            READ: begin
                data_d  = mem_di;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with it.
    always_comb begin
        rdy_d        = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        dma_active_d = (state_d == READ) || (state_d == WRITE);
        dma_rw_d     = (state_d != WRITE);
        dma_a_d      = dma_a_q;
        dma_do_d     = dma_do_q;
        case (state_d)
            READ: begin
                dma_a_d = {page_d, idx_d};
            end
            WRITE: begin
                dma_a_d  = DEST_ADDR;
                dma_do_d = data_d;
            end
            default: begin
                dma_a_d  = dma_a_q;
                dma_do_d = dma_do_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q        <= 1'b1;
            dma_active_q <= 1'b0;
            busy_q       <= 1'b0;
            dma_a_q      <= 16'h0000;
            dma_do_q     <= 8'h00;
            dma_rw_q     <= 1'b1;
        end else begin
            rdy_q        <= rdy_d;
            dma_active_q <= dma_active_d;
            busy_q       <= busy_d;
            dma_a_q      <= dma_a_d;
            dma_do_q     <= dma_do_d;
            dma_rw_q     <= dma_rw_d;
        end
    end

    assign rdy        = rdy_q;
    assign dma_active = dma_active_q;
    assign busy       = busy_q;
    assign dma_a      = dma_a_q;
    assign dma_do     = dma_do_q;
    assign dma_rw     = dma_rw_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: RAM model on mem_di, cycle-by-cycle checks of every transfer.
module tb_nes_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_rw;
    logic [7:0]  mem_di;
    logic        rdy;
    logic        dma_active;
    logic [15:0] dma_a;
    logic [7:0]  dma_do;
    logic        dma_rw;
    logic        busy;

    logic [7:0]  ram [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          low_cnt = 0;

    always #5 clk = ~clk;

    nes_oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_a      (cpu_a),
        .cpu_do     (cpu_do),
        .cpu_rw     (cpu_rw),
        .mem_di     (mem_di),
        .rdy        (rdy),
        .dma_active (dma_active),
        .dma_a      (dma_a),
        .dma_do     (dma_do),
        .dma_rw     (dma_rw),
        .busy       (busy)
    );

    assign mem_di = ram[dma_a];

    always @(negedge clk) if (rdy === 1'b0) low_cnt++;

    // Page 02 holds i^5A; other pages use a page-dependent key so a wrong page shows up.
    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        logic [7:0] key;
        key = (a[15:8] == 8'h02) ? 8'h5A : (a[15:8] ^ 8'hC3);
        return a[7:0] ^ key;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) cyc = 0; else cyc++;
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Make the next posedge land on cycle parity p (0 = even).
    task automatic wait_parity(input int p);
        cpu_rw = 1'b1;
        cpu_a  = 16'h0000;
        cpu_do = 8'h00;
        if (((cyc + 1) % 2) != p) tick();
    endtask

    task automatic run_xfer(input logic [7:0] pg, input int hold, input int exp_align,
                            input int abort_idx, input int exp_low);
        int          base;
        logic [15:0] a;
        cpu_a  = 16'h4014;
        cpu_do = pg;
        cpu_rw = 1'b0;
        base   = low_cnt;
        tick();
        chk1("halt_rdy", rdy, 1'b0);
        chk1("halt_busy", busy, 1'b1);
        chk1("halt_active", dma_active, 1'b0);
        for (int h = 0; h < hold; h++) begin
            cpu_do = ~pg;
            tick();
            chk1("hold_active", dma_active, 1'b0);
            chk1("hold_rdy", rdy, 1'b0);
        end
        cpu_rw = 1'b1;
        cpu_a  = 16'h8000;
        cpu_do = 8'h00;
        tick();
        for (int k = 0; k < exp_align; k++) begin
            chk1("align_active", dma_active, 1'b0);
            chk1("align_rdy", rdy, 1'b0);
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            a = {pg, i[7:0]};
            chk1("rd_active", dma_active, 1'b1);
            chk1("rd_rw", dma_rw, 1'b1);
            chk16("rd_addr", dma_a, a);
            chk1("rd_rdy", rdy, 1'b0);
            tick();
            chk1("wr_active", dma_active, 1'b1);
            chk1("wr_rw", dma_rw, 1'b0);
            chk16("wr_addr", dma_a, 16'h2004);
            chk8("wr_data", dma_do, exp_byte(a));
            if (i == abort_idx) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk1("abort_rdy", rdy, 1'b1);
                chk1("abort_active", dma_active, 1'b0);
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_rw", dma_rw, 1'b1);
                chk16("abort_addr", dma_a, 16'h0000);
                chk8("abort_data", dma_do, 8'h00);
                return;
            end
            tick();
        end
        chk1("done_rdy", rdy, 1'b1);
        chk1("done_busy", busy, 1'b0);
        chk1("done_active", dma_active, 1'b0);
        chk1("done_rw", dma_rw, 1'b1);
        chk16("done_addr_hold", dma_a, 16'h2004);
        chk8("done_data_hold", dma_do, exp_byte({pg, 8'hFF}));
        chkn("rdy_low_cycles", low_cnt - base, exp_low);
    endtask

    initial begin
        for (int j = 0; j < 65536; j++) ram[j] = exp_byte(j[15:0]);

        // Reset held with a trigger write on the bus.
        reset  = 1'b1;
        cpu_rw = 1'b0;
        cpu_a  = 16'h4014;
        cpu_do = 8'h77;
        tick();
        tick();
        chk1("rst_rdy", rdy, 1'b1);
        chk1("rst_active", dma_active, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rw", dma_rw, 1'b1);
        chk16("rst_addr", dma_a, 16'h0000);
        chk8("rst_data", dma_do, 8'h00);
        reset  = 1'b0;
        cpu_rw = 1'b1;
        tick();
        chk1("rst_no_start", busy, 1'b0);

        // Reads of 4014 and writes elsewhere are ignored.
        cpu_rw = 1'b1;
        cpu_a  = 16'h4014;
        tick();
        chk1("read_ignored", busy, 1'b0);
        cpu_rw = 1'b0;
        cpu_a  = 16'h4015;
        tick();
        chk1("other_addr_ignored", busy, 1'b0);
        chk1("other_addr_rdy", rdy, 1'b1);

        // Basic transfer, even alignment: 1 HALT + 1 ALIGN + 512.
        wait_parity(0);
        run_xfer(8'h02, 0, 1, -1, 514);

        // Shifted by one cycle: ALIGN takes 2 cycles.
        wait_parity(1);
        run_xfer(8'h02, 0, 2, -1, 515);

        // Three write cycles after the trigger, each rewriting 4014 with another page.
        wait_parity(1);
        run_xfer(8'h02, 3, 1, -1, 517);

        // Reset during the WRITE of idx 40, then a fresh transfer from page 03.
        wait_parity(0);
        run_xfer(8'h02, 0, 1, 8'h40, 0);
        wait_parity(0);
        run_xfer(8'h03, 0, 1, -1, 514);

        // Page FF, then a trigger in the very first IDLE cycle.
        wait_parity(0);
        run_xfer(8'hFF, 0, 1, -1, 514);
        run_xfer(8'h01, 0, 2, -1, 515);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
